// File: rtl/tcdm_bfly_master_shim.sv
// tcdm_bfly_master_shim
//   Bridges one TCDM master port onto the first stage of a butterfly
//   interconnect. The routing address and the packed request word go straight
//   through. Every granted transaction, read or write, returns exactly one
//   response through a small response FIFO. Responses come back in grant order.
//   Requests are throttled so the FIFO can always take every response in flight.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_i/gnt_o              master request handshake
//   add_i, wen_i, be_i,      master byte address, write enable (1=write),
//   wdata_i                  byte enables, write data
//   r_valid_o/r_ready_i      master response handshake
//   r_rdata_o                response data (FIFO head)
//   req_o/gnt_i              network request handshake
//   add_o                    routing address: word address bits of add_i
//   data_o                   {wen, be, wdata}
//   rdata_i                  network response data, valid one cycle after grant
//
// Configuration macro
//   TCDM_SHIM_RESP_BYPASS_EN  When defined, a response that arrives while the
//                             FIFO is empty is presented combinationally in
//                             its arrival cycle. It is stored only if the
//                             master does not accept it in that cycle.
module tcdm_bfly_master_shim #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddWidth  = 4,
    parameter int unsigned RespDepth = 2,
    localparam int unsigned BeWidth  = DataWidth / 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_i,
    output logic                         gnt_o,
    input  logic [AddrWidth-1:0]         add_i,
    input  logic                         wen_i,
    input  logic [BeWidth-1:0]           be_i,
    input  logic [DataWidth-1:0]         wdata_i,
    output logic                         r_valid_o,
    input  logic                         r_ready_i,
    output logic [DataWidth-1:0]         r_rdata_o,
    output logic                         req_o,
    input  logic                         gnt_i,
    output logic [AddWidth-1:0]          add_o,
    output logic [DataWidth+BeWidth:0]   data_o,
    input  logic [DataWidth-1:0]         rdata_i
);

    localparam int unsigned ByteOff = $clog2(BeWidth);
    localparam int unsigned CntW    = $clog2(RespDepth + 1);
    localparam int unsigned OccW    = CntW + 1;
    localparam int unsigned PtrW    = (RespDepth > 1) ? $clog2(RespDepth) : 1;

    logic [CntW-1:0]      cnt_q;
    logic                 infl_q;
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [DataWidth-1:0] mem_q [RespDepth];

    logic pop, fifo_pop, push, issue_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RespDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Only the word-address bits select a route; the rest of add_i is ignored.
    logic unused_add;
    assign unused_add = ^add_i;

    assign add_o  = add_i[ByteOff +: AddWidth];
    assign data_o = {wen_i, be_i, wdata_i};

    assign pop = r_valid_o & r_ready_i;

    // Outstanding = stored responses + the one still on the network. A new
    // grant is allowed only if a FIFO slot will be free when it returns.
    // A pop in this cycle frees one slot.
    assign issue_ok = (OccW'(cnt_q) + OccW'(infl_q)) < (OccW'(RespDepth) + OccW'(pop));

    // Gated with reset so that nothing leaks onto the network while in reset.
    assign req_o = rst_ni & req_i & issue_ok;
    assign gnt_o = req_o & gnt_i;

`ifdef TCDM_SHIM_RESP_BYPASS_EN
    logic bypass;
    assign bypass    = infl_q & (cnt_q == '0);
    assign r_valid_o = (cnt_q != '0) | bypass;
    assign r_rdata_o = bypass ? rdata_i : mem_q[rd_ptr_q];
    assign push      = infl_q & ~(bypass & r_ready_i);
`else
    assign r_valid_o = (cnt_q != '0);
    assign r_rdata_o = mem_q[rd_ptr_q];
    assign push      = infl_q;
`endif

    // A bypassed pop never touches the FIFO.
    assign fifo_pop = pop & (cnt_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            infl_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            infl_q <= gnt_o;
            cnt_q  <= cnt_q + CntW'(push) - CntW'(fifo_pop);
            if (push)     wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (fifo_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    // Storage is not reset: entries are unobservable while cnt_q is zero.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= rdata_i;
    end

    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && !fifo_pop && (cnt_q == CntW'(RespDepth))));

endmodule

// File: doc/tcdm_bfly_master_shim.md
TCDM_BFLY_MASTER_SHIM -- requirements
Module: tcdm_bfly_master_shim

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, master byte-address width.
REQ-002 SHALL have parameter DataWidth, default 32, write/read data width; BeWidth = DataWidth/8, ByteOff = log2(BeWidth).
REQ-003 SHALL have parameter AddWidth, default 4, routing-address width driven into the first butterfly stage.
REQ-004 SHALL have parameter RespDepth, default 2, response FIFO depth (>=1).
REQ-005 SHALL have ports: clk_i in 1 clock; rst_ni in 1 reset, asynchronous, active-low.
REQ-006 SHALL have master request ports: req_i in 1; gnt_o out 1; add_i in AddrWidth; wen_i in 1 (1=write); be_i in BeWidth; wdata_i in DataWidth.
REQ-007 SHALL have master response ports: r_valid_o out 1; r_ready_i in 1; r_rdata_o out DataWidth.
REQ-008 SHALL have network ports: req_o out 1; gnt_i in 1; add_o out AddWidth; data_o out DataWidth+BeWidth+1; rdata_i in DataWidth (valid exactly one cycle after req_o&gnt_i).

Function
REQ-009 SHALL drive add_o = add_i[ByteOff +: AddWidth] and data_o = {wen_i, be_i, wdata_i} combinationally.
REQ-010 SHALL compute issue_ok = (cnt_q + infl_q) < (RespDepth + pop), pop = r_valid_o & r_ready_i.
REQ-011 SHALL drive req_o = req_i & issue_ok and gnt_o = req_o & gnt_i; no request is registered or reordered.
REQ-012 SHALL set infl_q to 1 in the cycle after req_o&gnt_i, else 0; it never exceeds 1.
REQ-013 SHALL produce one response per granted transaction, reads and writes alike; a write response carries rdata_i unchanged.
REQ-014 SHALL push rdata_i into the FIFO when infl_q=1 (subject to REQ-024), so r_valid_o rises two cycles after the grant cycle.
REQ-015 SHALL drive r_valid_o = (cnt_q != 0) and r_rdata_o = FIFO head; both SHALL be held stable while r_valid_o & ~r_ready_i.
REQ-016 SHALL pop the head on r_valid_o & r_ready_i; pointers wrap modulo RespDepth.
REQ-017 SHALL update cnt_q by +push -pop; simultaneous push and pop leaves cnt_q unchanged.
REQ-018 SHALL never overflow: REQ-010 guarantees cnt_q <= RespDepth; a push when full SHALL trigger an assertion failure.
REQ-019 SHALL sustain one grant per cycle with RespDepth=2 and r_ready_i held 1.
REQ-020 SHALL, when cnt_q + infl_q == RespDepth and no pop occurs, hold req_o=0 and gnt_o=0 regardless of req_i.
REQ-021 SHALL return responses in grant order.

Reset
REQ-022 SHALL, on rst_ni low, asynchronously clear cnt_q, infl_q, and both FIFO pointers; r_valid_o=0, req_o=0, gnt_o=0 while in reset.
REQ-023 SHALL discard any response in flight when reset asserts mid-transaction; FIFO contents are not cleared, since they are unobservable while cnt_q=0.

Configuration
REQ-024 SHALL support macro TCDM_SHIM_RESP_BYPASS_EN. When it is defined and infl_q=1 with cnt_q=0: r_valid_o=1 and r_rdata_o=rdata_i combinationally, one cycle after grant; push occurs only if r_ready_i=0. When it is undefined, behaviour follows REQ-014/015 with no combinational rdata_i-to-r_rdata_o path.

Verification
REQ-025 SHALL cover single read: add_i=0x34, req_i 1 cycle, gnt_i=1, rdata_i=0xDEADBEEF at T+1. Required response: add_o=0xD, r_valid_o=1 with r_rdata_o=0xDEADBEEF at T+2 (T+1 with bypass).
REQ-026 SHALL cover back-to-back: 8 requests, gnt_i=1, r_ready_i=1. Required response: 8 grants in 8 consecutive cycles, 8 in-order responses, no stall.
REQ-027 SHALL cover backpressure: r_ready_i=0 and 4 requests issued. Required response: only 2 grants, req_o=0 thereafter; after r_ready_i=1, the remaining 2 are granted and all 4 responses are returned in order.
REQ-028 SHALL cover network stall: gnt_i=0 for 3 cycles with req_i=1. Required response: gnt_o=0, infl_q=0, and no response until gnt_i=1.
REQ-029 SHALL cover write packing: wen_i=1, be_i=0x5, wdata_i=0x12345678. Required response: data_o={1,0x5,0x12345678} and one response returned.
REQ-030 SHALL cover reset mid-operation: assert rst_ni low with cnt_q=2, infl_q=1. Required response: r_valid_o=0 immediately, with no stale response after release.
